// File: rtl/vpack.sv
`default_nettype none
// ============================================================================
// vpack : streaming variable-width bit packer, emits dense VLEN-bit words
// Rev 1.0
// ============================================================================
module vpack #(
   parameter int VLEN = 256,
   parameter int BSW  = 5,
   parameter int EW   = 8,
   parameter int LW   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [BSW:0]                   inum,
   input  logic [(1<<BSW)-1:0][LW-1:0]    ilen,
   input  logic [(1<<BSW)-1:0][EW-1:0]    idata,
   input  logic                           ilast,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [VLEN-1:0]                odata,
   output logic [$clog2(VLEN):0]          obits,
   output logic                           olast
);
   localparam int BS = 1 << BSW;
   localparam int AW = 2 * VLEN;
   localparam int FW = $clog2(AW);
   localparam int OW = $clog2(VLEN) + 1;
   localparam int PW = BS * EW;

   localparam logic [BSW:0]  C_BS     = (BSW+1)'(BS);
   localparam logic [LW-1:0] C_EW     = LW'(EW);
   localparam logic [FW-1:0] C_VLEN   = FW'(VLEN);
   localparam logic [EW-1:0] C_EW_ONE = EW'(1);

   typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [FW-1:0]   fill_q, fill_d;

   logic [BSW:0]    num_s;
   logic [LW-1:0]   len_s;
   logic [EW:0]     one_sh;
   logic [EW-1:0]   elem;
   logic [FW-1:0]   tot;
   logic [PW-1:0]   pk;

   // Beat packer: sanitised elements concatenated into a dense LSB-first field
   always_comb begin
      num_s  = (inum > C_BS) ? C_BS : inum;
      pk     = '0;
      tot    = '0;
      len_s  = '0;
      one_sh = '0;
      elem   = '0;
      for (int j = 0; j < BS; j++) begin
         if ((BSW+1)'(j) < num_s) begin
            len_s  = (ilen[j] > C_EW) ? C_EW : ilen[j];
            one_sh = (EW+1)'(1) << len_s;
            elem   = idata[j] & (one_sh[EW-1:0] - C_EW_ONE);
            pk     = pk | (PW'(elem) << tot);
            tot    = tot + FW'(len_s);
         end
      end
   end

   logic          push, pop;
   logic [FW-1:0] base;
   logic [AW-1:0] shifted;

   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      odata     = acc_q[VLEN-1:0];
      obits     = OW'(VLEN);
      olast     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FILL: begin
               out_valid = (fill_q >= C_VLEN);
               in_ready  = (fill_q < C_VLEN) || out_ready;
            end
            S_DRAIN: begin
               out_valid = 1'b1;
               obits     = (fill_q >= C_VLEN) ? OW'(VLEN) : OW'(fill_q);
               olast     = (fill_q <= C_VLEN);
            end
            default: ;
         endcase
      end
   end

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      fill_d  = fill_q;
      base    = fill_q;
      shifted = acc_q;
      if (pop && olast) begin
         acc_d   = '0;
         fill_d  = '0;
         state_d = S_FILL;
      end else begin
         if (pop) begin
            shifted = acc_q >> VLEN;
            base    = fill_q - C_VLEN;
         end
         // base < VLEN whenever a push is accepted, so the field always fits
         if (push) begin
            acc_d  = shifted | (AW'(pk) << base);
            fill_d = base + tot;
            if (ilast)
               state_d = S_DRAIN;
         end else begin
            acc_d  = shifted;
            fill_d = base;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         acc_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vpack.sv
`default_nettype none
// ============================================================================
// tb_vpack : randomized + directed bench for vpack against a bit-queue model
// Rev 1.0
// ============================================================================
module tb_vpack;
   localparam int VLEN = 256;
   localparam int BSW  = 5;
   localparam int BS   = 1 << BSW;
   localparam int EW   = 8;
   localparam int LW   = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [BSW:0]             inum;
   logic [BS-1:0][LW-1:0]    ilen;
   logic [BS-1:0][EW-1:0]    idata;
   logic                     ilast;
   logic                     out_valid;
   logic                     out_ready;
   logic [VLEN-1:0]          odata;
   logic [$clog2(VLEN):0]    obits;
   logic                     olast;

   always #5 clk = ~clk;

   vpack #(.VLEN(VLEN), .BSW(BSW), .EW(EW), .LW(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .inum     (inum),
      .ilen     (ilen),
      .idata    (idata),
      .ilast    (ilast),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .odata    (odata),
      .obits    (obits),
      .olast    (olast)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: the stream is just a queue of bits plus a "stream ended" flag
   bit mq[$];
   bit mdrain = 1'b0;

   task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic            ev, er, el;
      logic [VLEN-1:0] ew;
      int              nb, n, len;
      bit              nbits[$];
      @(negedge clk);
      ev = 1'b0; er = 1'b0; el = 1'b0; nb = 0;
      if (!rst) begin
         ev = mdrain || (mq.size() >= VLEN);
         er = !mdrain && ((mq.size() < VLEN) || out_ready);
      end
      chk("out_valid", VLEN'(out_valid), VLEN'(ev));
      chk("in_ready", VLEN'(in_ready), VLEN'(er));
      if (ev) begin
         nb = mdrain ? ((mq.size() < VLEN) ? mq.size() : VLEN) : VLEN;
         el = mdrain && (mq.size() <= VLEN);
         ew = '0;
         for (int k = 0; k < nb; k++) ew[k] = mq[k];
         chk("odata", odata, ew);
         chk("obits", VLEN'(obits), VLEN'(nb));
         chk("olast", VLEN'(olast), VLEN'(el));
      end
      if (er && in_valid) begin
         n = (int'(inum) > BS) ? BS : int'(inum);
         for (int j = 0; j < n; j++) begin
            len = (int'(ilen[j]) > EW) ? EW : int'(ilen[j]);
            for (int k = 0; k < len; k++) nbits.push_back(idata[j][k]);
         end
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mdrain = 1'b0;
      end else begin
         if (ev && out_ready) begin
            if (el) begin
               mq.delete();
               mdrain = 1'b0;
            end else begin
               for (int k = 0; k < VLEN; k++) void'(mq.pop_front());
            end
         end
         if (er && in_valid) begin
            foreach (nbits[k]) mq.push_back(nbits[k]);
            if (ilast) mdrain = 1'b1;
         end
      end
      #1;
   endtask

   task automatic set_beat(input int n, input int len, input bit last);
      inum = (BSW+1)'(n);
      for (int j = 0; j < BS; j++) begin
         ilen[j]  = LW'(len);
         idata[j] = EW'(j);
      end
      ilast    = last;
      in_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; ilast = 1'b0;
      inum = '0; ilen = '0; idata = '0;

      // Reset holds both handshakes low even with in_valid asserted
      repeat (3) step();
      rst = 1'b0; in_valid = 1'b0;
      #1 chk("rst_in_ready_after", VLEN'(in_ready), VLEN'(1));
      step();

      // Full beat: 32 bytes, byte j = j
      out_ready = 1'b1;
      set_beat(32, 8, 1'b0);
      step();
      in_valid = 1'b0;
      chk("full_valid", VLEN'(out_valid), VLEN'(1));
      chk("full_byte1", VLEN'(odata[15:8]), VLEN'(1));
      chk("full_byte31", VLEN'(odata[255:248]), VLEN'(31));
      step();
      step();

      // Mixed lengths closing the stream
      set_beat(3, 0, 1'b1);
      ilen[0] = 4'd3; ilen[1] = 4'd5; ilen[2] = 4'd4;
      idata[0] = 8'hFF; idata[1] = 8'h01; idata[2] = 8'hAA;
      step();
      in_valid = 1'b0; ilast = 1'b0;
      chk("mixed_odata", odata, VLEN'(12'hA0F));
      chk("mixed_obits", VLEN'(obits), VLEN'(12));
      chk("mixed_olast", VLEN'(olast), VLEN'(1));
      step();
      step();

      // Straddle: 250 bits, then 16 more under backpressure
      out_ready = 1'b0;
      set_beat(32, 8, 1'b0);
      ilen[31] = 4'd2;
      step();
      set_beat(2, 8, 1'b0);
      idata[0] = 8'h5A; idata[1] = 8'hC3;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("strad_valid", VLEN'(out_valid), VLEN'(1));
         chk("strad_in_ready", VLEN'(in_ready), VLEN'(0));
         step();
      end
      out_ready = 1'b1;
      step();
      set_beat(0, 0, 1'b1);
      step();
      in_valid = 1'b0; ilast = 1'b0;
      chk("strad_rem_odata", odata, VLEN'(10'h30D));
      chk("strad_rem_obits", VLEN'(obits), VLEN'(10));
      step();

      // Empty stream right after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_beat(0, 0, 1'b1);
      step();
      in_valid = 1'b0; ilast = 1'b0;
      chk("empty_obits", VLEN'(obits), VLEN'(0));
      chk("empty_olast", VLEN'(olast), VLEN'(1));
      chk("empty_odata", odata, '0);
      step();

      // Reset while draining 300 bits
      out_ready = 1'b0;
      set_beat(32, 8, 1'b0);
      ilen[31] = 4'd2;
      step();
      set_beat(7, 8, 1'b1);
      ilen[6] = 4'd2;
      step();
      in_valid = 1'b0; ilast = 1'b0;
      chk("mid_drain_olast", VLEN'(olast), VLEN'(0));
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", VLEN'(out_valid), VLEN'(0));
      out_ready = 1'b1;
      repeat (3) step();

      // Random traffic, including oversize inum/ilen and occasional resets
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         inum      = (BSW+1)'($urandom_range(0, 40));
         for (int j = 0; j < BS; j++) begin
            ilen[j]  = LW'($urandom_range(0, 15));
            idata[j] = EW'($urandom);
         end
         ilast = ($urandom_range(0, 7) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vpack.md
Name: vpack

Overview:
- Streaming variable-width bit packer: the transmit-side counterpart of the pidx extraction path.
- Each input beat carries up to BS elements, each up to EW bits wide with its own bit length.
- Valid bits of consecutive elements are concatenated LSB-first into a dense bitstream.
- The bitstream is emitted as VLEN-bit words over a valid/ready interface, with a final partial word on stream end.

Parameters:
- VLEN, 256, output word width in bits; must be a power of two.
- BSW, 5, log2 of elements per input beat; BS = 1<<BSW.
- EW, 8, maximum element width in bits; BS*EW must not exceed VLEN.
- LW, 4, width of each element-length field.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- inum  input  BSW+1  number of valid elements in the beat, 0..BS.
- ilen  input  LW x BS  bit length of each element, 0..EW.
- idata  input  EW x BS  element payloads, LSB-aligned.
- ilast  input  1  beat is the last of the stream.
- out_valid  output  1  output word valid.
- out_ready  input  1  output word consumed when out_valid && out_ready.
- odata  output  VLEN  packed bits, LSB = earliest bit.
- obits  output  log2(VLEN)+1  count of meaningful bits in odata, 0..VLEN.
- olast  output  1  word is the final word of the stream.

Behaviour:
- Clock, reset: single clock clk; reset rst is synchronous and active-high.
- Storage:
  - acc is a 2*VLEN-bit accumulator register.
  - fill is the count of bits held in acc, 0..2*VLEN-1.
  - state is FILL or DRAIN.
- Reset: state=FILL, fill=0, acc=0, out_valid=0, in_ready=0 while rst is high. in_ready is 1 in the first cycle after reset.
- Input sanitising:
  - inum>BS is treated as BS.
  - ilen>EW is treated as EW.
  - Elements j>=inum contribute 0 bits.
  - idata bits at positions >= ilen[j] are masked to 0.
- Placement:
  - off[j] = sum of ilen[i] for i<j (exclusive prefix sum).
  - T = sum of ilen[j] for j<inum, so 0 <= T <= BS*EW.
  - Element j is written at acc bit (base + off[j]).
  - base = fill, or fill-VLEN if a pop occurs in the same cycle.
- FILL state:
  - out_valid = (fill >= VLEN); odata = acc[VLEN-1:0]; obits = VLEN; olast = 0.
  - in_ready = (fill < VLEN) || out_ready. This is combinational from out_ready.
- Pop on output handshake: acc shifts right by VLEN and fill decreases by VLEN.
- Simultaneous push and pop in one cycle:
  - New acc = (acc>>VLEN) with the new bits inserted at fill-VLEN.
  - New fill = fill - VLEN + T.
  - Fill never exceeds 2*VLEN-1.
- Latency: a beat that makes fill>=VLEN produces out_valid in the next cycle. Full throughput is sustained at one beat per cycle while out_ready=1.
- ilast accepted: the beat's bits are added, then state goes to DRAIN.
- DRAIN state:
  - in_ready = 0; out_valid = 1; odata = acc[VLEN-1:0].
  - obits = min(fill, VLEN); olast = (fill <= VLEN).
  - A handshake with olast=0 pops as in FILL.
  - A handshake with olast=1 sets fill=0, clears acc, and returns to FILL.
- Empty stream: ilast accepted with fill=0 and T=0 emits one word with obits=0, olast=1.
- Exact multiple: if the remainder is exactly VLEN, that word carries obits=VLEN and olast=1, and no extra word follows.
- Backpressure: while out_valid=1 and out_ready=0, odata, obits and olast stay stable.
- Unused bits: bits of odata above obits are 0.
- Reset mid-stream: all buffered bits are discarded and the state restarts as at reset, with no word emitted.

Test Plan:
- Reset: assert rst for 3 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; in_ready=1 in the first cycle after rst falls.
- Full beat: inum=32, ilen[j]=8, idata[j]=j -> out_valid the next cycle, odata byte j = j, obits=256, olast=0, then fill=0.
- Mixed lengths: inum=3, ilen={3,5,4}, idata={0xFF,0x01,0xAA}, ilast=1 -> one DRAIN word with odata=0xA0F, obits=12, olast=1, then state FILL.
- Straddle with backpressure: preload 250 bits, push a 16-bit beat with out_ready=0 -> out_valid=1, in_ready=0, odata stable for 5 cycles; raising out_ready pops the word and leaves fill=10 holding the upper bits.
- Empty stream: ilast with inum=0 from reset -> single word with obits=0, olast=1, odata=0.
- Reset mid-DRAIN: ilast after 300 bits, out_ready=0, then assert rst -> out_valid=0 next cycle, fill=0, and no olast word is emitted.
